// File: rtl/gpio_loader_pkg.sv
// Shared definitions for the GPIO serial configuration loader.
//   state_t     : loader FSM encoding
//   DEF_CFG_W   : default configuration word width per pad
//   DEF_NUM_IO  : default number of GPIO control blocks on the chain
package gpio_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } state_t;

  localparam int unsigned DEF_CFG_W  = 13;
  localparam int unsigned DEF_NUM_IO = 19;

endpackage

// File: rtl/gpio_loader_clkdiv.sv
// Half-period tick generator for the serial chain clock.
//   clk   : system clock
//   rst_n : active-low asynchronous reset (already deassert-synchronized)
//   en    : count while high; counter is held at zero while low
//   tick  : high on the last cycle of each CLK_DIV-cycle half-period
module gpio_loader_clkdiv #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// Serial loader for the GPIO pad configuration chain. Captures all pad
// configuration words on start, shifts them out MSB-first (pad NUM_IO-1
// first) with a divided shift clock, then pulses serial_load.
//   wb_clk_i     : clock
//   wb_rstn_i    : asynchronous active-low reset (deassertion synchronized)
//   start        : single-cycle transfer request, honoured only in IDLE
//   cfg_words    : pad i word at [i*CFG_W +: CFG_W]
//   busy / done  : transfer in progress / one-cycle completion pulse
//   serial_clock, serial_data, serial_load : chain interface
// Optional build macro GPIO_LOADER_BITBANG_EN adds bb_enable, bb_clock,
// bb_data and bb_load, letting software drive the chain directly while IDLE.
module gpio_serial_loader
  import gpio_loader_pkg::*;
#(
  parameter int unsigned NUM_IO  = DEF_NUM_IO,
  parameter int unsigned CFG_W   = DEF_CFG_W,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rstn_i,
  input  logic                      start,
  input  logic [NUM_IO*CFG_W-1:0]   cfg_words,
`ifdef GPIO_LOADER_BITBANG_EN
  input  logic                      bb_enable,
  input  logic                      bb_clock,
  input  logic                      bb_data,
  input  logic                      bb_load,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      serial_clock,
  output logic                      serial_data,
  output logic                      serial_load
);

  localparam int unsigned TOT_W = NUM_IO * CFG_W;
  localparam int unsigned BIT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam int unsigned PAD_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_W - 1);
  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(NUM_IO - 1);

  logic [1:0]       rst_sync;
  logic             rst_n;
  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [PAD_W-1:0] pad_cnt;
  logic [TOT_W-1:0] shadow;
  logic [TOT_W-1:0] shadow_next;
  logic             div_en;
  logic             tick;

  // Assert immediately, release two clocks after wb_rstn_i rises.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  assign div_en      = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LOAD);
  // The shadow is consumed from its MSB, which is exactly pad NUM_IO-1 bit
  // CFG_W-1, so shifting left walks the required bit order.
  assign shadow_next = shadow << 1;

  gpio_loader_clkdiv #(
    .CLK_DIV (CLK_DIV)
  ) u_clkdiv (
    .clk   (wb_clk_i),
    .rst_n (rst_n),
    .en    (div_en),
    .tick  (tick)
  );

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      pad_cnt      <= '0;
      shadow       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
`ifdef GPIO_LOADER_BITBANG_EN
          if (bb_enable) begin
            serial_clock <= bb_clock;
            serial_data  <= bb_data;
            serial_load  <= bb_load;
          end else
`endif
          if (start) begin
            state        <= SHIFT_LO;
            shadow       <= cfg_words;
            bit_cnt      <= '0;
            pad_cnt      <= '0;
            busy         <= 1'b1;
            serial_clock <= 1'b0;
            serial_data  <= cfg_words[TOT_W-1];
            serial_load  <= 1'b0;
          end else begin
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
          end
        end

        SHIFT_LO: begin
          if (tick) begin
            state        <= SHIFT_HI;
            serial_clock <= 1'b1;
          end
        end

        SHIFT_HI: begin
          if (tick) begin
            serial_clock <= 1'b0;
            if ((bit_cnt == BIT_LAST) && (pad_cnt == PAD_LAST)) begin
              state       <= LOAD;
              serial_data <= 1'b0;
              serial_load <= 1'b1;
            end else begin
              state       <= SHIFT_LO;
              shadow      <= shadow_next;
              serial_data <= shadow_next[TOT_W-1];
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                pad_cnt <= pad_cnt + PAD_W'(1);
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end
        end

        LOAD: begin
          if (tick) begin
            state       <= DONE;
            serial_load <= 1'b0;
            done        <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          done         <= 1'b0;
          serial_clock <= 1'b0;
          serial_data  <= 1'b0;
          serial_load  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
module tb_gpio_serial_loader;

  localparam int unsigned NIO = 2;
  localparam int unsigned CW  = 13;
  localparam int unsigned TW  = NIO * CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          start [2];
  logic [TW-1:0] cfg   [2];
  logic          busy  [2];
  logic          done  [2];
  logic          sclk  [2];
  logic          sdata [2];
  logic          sload [2];
`ifdef GPIO_LOADER_BITBANG_EN
  logic          bb_en  [2];
  logic          bb_clk [2];
  logic          bb_dat [2];
  logic          bb_ld  [2];
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  logic q [$];

  localparam logic [TW-1:0] WORDS_A = {13'h1803, 13'h0402};
  localparam logic [TW-1:0] WORDS_B = {13'h0A5C, 13'h15A3};

  gpio_serial_loader #(.NUM_IO(NIO), .CFG_W(CW), .CLK_DIV(1)) dut1 (
    .wb_clk_i     (clk),
    .wb_rstn_i    (rstn),
    .start        (start[0]),
    .cfg_words    (cfg[0]),
`ifdef GPIO_LOADER_BITBANG_EN
    .bb_enable    (bb_en[0]),
    .bb_clock     (bb_clk[0]),
    .bb_data      (bb_dat[0]),
    .bb_load      (bb_ld[0]),
`endif
    .busy         (busy[0]),
    .done         (done[0]),
    .serial_clock (sclk[0]),
    .serial_data  (sdata[0]),
    .serial_load  (sload[0])
  );

  gpio_serial_loader #(.NUM_IO(NIO), .CFG_W(CW), .CLK_DIV(3)) dut3 (
    .wb_clk_i     (clk),
    .wb_rstn_i    (rstn),
    .start        (start[1]),
    .cfg_words    (cfg[1]),
`ifdef GPIO_LOADER_BITBANG_EN
    .bb_enable    (bb_en[1]),
    .bb_clock     (bb_clk[1]),
    .bb_data      (bb_dat[1]),
    .bb_load      (bb_ld[1]),
`endif
    .busy         (busy[1]),
    .done         (done[1]),
    .serial_clock (sclk[1]),
    .serial_data  (sdata[1]),
    .serial_load  (sload[1])
  );

  // Drives one transfer on instance idx and checks bit order, phase widths,
  // load width, latency and busy span. With disturb set, start is pulsed
  // mid-transfer and in the DONE cycle, and cfg_words is changed.
  task automatic run_transfer(input int unsigned idx, input int unsigned cd,
                              input logic [TW-1:0] words, input bit disturb);
    int unsigned lat, done_t, busy_n, load_n, hi_len, lo_len;
    logic exp_bit, prev_sclk;
    lat = 1 + 2 * cd * TW + cd;
    q.delete();
    for (int i = TW - 1; i >= 0; i--) q.push_back(words[i]);
    @(negedge clk);
    cfg[idx]   = words;
    start[idx] = 1'b1;
    prev_sclk = 1'b0; done_t = 0; busy_n = 0; load_n = 0;
    hi_len = 0; lo_len = 0; exp_bit = 1'b0;
    for (int unsigned t = 1; t <= lat + 4; t++) begin
      @(negedge clk);
      start[idx] = disturb && (t == 10 || t == lat / 2 || t == lat);
      if (disturb && t == 20) cfg[idx] = ~words;
      if (busy[idx]) busy_n++;
      if (sclk[idx]) begin
        if (!prev_sclk) begin
          n_checks++;
          if (lo_len !== cd) begin
            n_fail++;
            $display("FAIL low_phase: got %0d cycles, expected %0d", lo_len, cd);
          end
          n_checks++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_bit: got rising clock at t=%0d, expected no more bits", t);
          end else begin
            exp_bit = q.pop_front();
          end
          hi_len = 0;
          lo_len = 0;
        end
        hi_len++;
        n_checks++;
        if (sdata[idx] !== exp_bit) begin
          n_fail++;
          $display("FAIL serial_data: got %b at t=%0d, expected %b", sdata[idx], t, exp_bit);
        end
      end else begin
        if (prev_sclk) begin
          n_checks++;
          if (hi_len !== cd) begin
            n_fail++;
            $display("FAIL high_phase: got %0d cycles, expected %0d", hi_len, cd);
          end
        end
        if (busy[idx]) lo_len++;
      end
      if (sload[idx]) begin
        load_n++;
        n_checks++;
        if (sclk[idx] !== 1'b0 || sdata[idx] !== 1'b0) begin
          n_fail++;
          $display("FAIL load_lines: got clk=%b data=%b, expected 0 0", sclk[idx], sdata[idx]);
        end
      end
      if (done[idx]) begin
        n_checks++;
        if (done_t != 0 || sdata[idx] !== 1'b0 || sload[idx] !== 1'b0) begin
          n_fail++;
          $display("FAIL done_cycle: got t=%0d first=%0d data=%b load=%b, expected single pulse, 0 0",
                   t, done_t, sdata[idx], sload[idx]);
        end
        if (done_t == 0) done_t = t;
      end
      prev_sclk = sclk[idx];
    end
    start[idx] = 1'b0;
    n_checks++;
    if (done_t !== lat) begin
      n_fail++;
      $display("FAIL latency: got %0d, expected %0d", done_t, lat);
    end
    n_checks++;
    if (busy_n !== lat) begin
      n_fail++;
      $display("FAIL busy_cycles: got %0d, expected %0d", busy_n, lat);
    end
    n_checks++;
    if (load_n !== cd) begin
      n_fail++;
      $display("FAIL load_cycles: got %0d, expected %0d", load_n, cd);
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_bits: got %0d unshifted, expected 0", q.size());
    end
    n_checks++;
    if ({busy[idx], sclk[idx], sdata[idx], sload[idx]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after: got %b, expected 0000",
               {busy[idx], sclk[idx], sdata[idx], sload[idx]});
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      cfg[i]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({busy[i], done[i], sclk[i], sdata[i], sload[i]} !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got %b, expected 00000", i,
                 {busy[i], done[i], sclk[i], sdata[i], sload[i]});
      end
    end
    // start held over the first two cycles after release must be ignored
    rstn       = 1'b1;
    start[0]   = 1'b1;
    cfg[0]     = WORDS_A;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (busy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL early_start: got busy=%b cycle %0d after release, expected 0", busy[0], k + 1);
      end
    end
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_shift_pattern();
    run_transfer(0, 1, WORDS_A, 1'b0);
  endtask

  task automatic test_clk_div();
    run_transfer(1, 3, WORDS_B, 1'b0);
  endtask

  task automatic test_ignore_start();
    run_transfer(0, 1, WORDS_B, 1'b1);
    run_transfer(1, 3, WORDS_A, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_transfer(0, 1, ~WORDS_A, 1'b0);
    run_transfer(0, 1, WORDS_A ^ WORDS_B, 1'b0);
  endtask

  task automatic test_reset_abort();
    int unsigned rises, loads;
    logic prev;
    rises = 0; loads = 0; prev = 1'b0;
    @(negedge clk);
    cfg[0]   = WORDS_A;
    start[0] = 1'b1;
    for (int unsigned t = 0; t < 100 && rises < 6; t++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (sclk[0] && !prev) rises++;
      prev = sclk[0];
    end
    n_checks++;
    if (rises !== 6) begin
      n_fail++;
      $display("FAIL reach_bit7: got %0d rising clocks, expected 6", rises);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy[0], done[0], sclk[0], sdata[0], sload[0]} !== 5'b00000) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b, expected 00000",
               {busy[0], done[0], sclk[0], sdata[0], sload[0]});
    end
    repeat (4) begin
      @(negedge clk);
      if (sload[0]) loads++;
    end
    rstn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (sload[0]) loads++;
    end
    n_checks++;
    if (loads !== 0) begin
      n_fail++;
      $display("FAIL abort_load: got %0d load cycles, expected 0", loads);
    end
    run_transfer(0, 1, WORDS_A, 1'b0);
  endtask

`ifdef GPIO_LOADER_BITBANG_EN
  task automatic test_bitbang();
    logic [2:0] pat, prev_pat;
    prev_pat = 3'b000;
    @(negedge clk);
    bb_en[0] = 1'b1;
    start[0] = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      pat = 3'((i * 5 + 1) % 8);
      bb_clk[0] = pat[0];
      bb_dat[0] = pat[1];
      bb_ld[0]  = pat[2];
      @(negedge clk);
      n_checks++;
      if ({sload[0], sdata[0], sclk[0]} !== pat || busy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bitbang_mirror: got %b busy=%b, expected %b busy=0",
                 {sload[0], sdata[0], sclk[0]}, busy[0], pat);
      end
      prev_pat = pat;
    end
    start[0] = 1'b0;
    bb_en[0] = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({sload[0], sdata[0], sclk[0], busy[0]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL bitbang_release: got %b (last pattern %b), expected 0000",
               {sload[0], sdata[0], sclk[0], busy[0]}, prev_pat);
    end
  endtask
`endif

  initial begin
`ifdef GPIO_LOADER_BITBANG_EN
    for (int i = 0; i < 2; i++) begin
      bb_en[i] = 1'b0; bb_clk[i] = 1'b0; bb_dat[i] = 1'b0; bb_ld[i] = 1'b0;
    end
`endif
    test_reset();
    test_shift_pattern();
    test_clk_div();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
`ifdef GPIO_LOADER_BITBANG_EN
    test_bitbang();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
